intersection_arbiter: RTL and testbench

INTERSECTION_ARBITER -- requirements
Module: intersection_arbiter

---
 rtl/intersection_arbiter_if.sv | 22 ++
 rtl/intersection_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_intersection_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/intersection_arbiter_if.sv
// Request and lamp signals of the intersection arbiter.
// The controller (master) drives requests; the arbiter (slave) drives lamps, tick and phase.
interface intersection_arbiter_if;
    logic       main_req;
    logic       side_req;
    logic       walk_req;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_light;
    logic       tick;
    logic [2:0] phase;

    modport master (
        output main_req, side_req, walk_req,
        input  main_light, side_light, walk_light, tick, phase
    );

    modport slave (
        input  main_req, side_req, walk_req,
        output main_light, side_light, walk_light, tick, phase
    );
endinterface

// File: rtl/intersection_arbiter.sv
// Two-road traffic light arbiter: main road rests green, side road and pedestrians are served on demand.
// Define PED_PHASE_EN to build the WALK phase and the side/walk round-robin pointer.
module intersection_arbiter #(
    parameter int unsigned DIV       = 5,
    parameter int unsigned MIN_GREEN = 6,
    parameter int unsigned MAX_GREEN = 12,
    parameter int unsigned YELLOW    = 2,
    parameter int unsigned WALK_TIME = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    intersection_arbiter_if.slave bus
);
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CNT_LIM = MAX_GREEN + MIN_GREEN + YELLOW + WALK_TIME;
    localparam int unsigned CNT_W   = $clog2(CNT_LIM + 1);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    typedef enum logic [2:0] {
        MAIN_G  = 3'd0,
        MAIN_Y  = 3'd1,
        ALL_RED = 3'd2,
        SIDE_G  = 3'd3,
        SIDE_Y  = 3'd4,
        WALK    = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [CNT_W-1:0] phase_cnt;
    logic             tick_q;
    logic             side_pend;
    logic             walk_pend;
    logic             ptr_walk;
    logic             from_main;
    logic             enter_side_c;
    logic [2:0]       main_nxt;
    logic [2:0]       side_nxt;
    logic [2:0]       main_q;
    logic [2:0]       side_q;
    logic [2:0]       phase_q;

    // main_req is informational only: the main road is the rest phase.
`ifdef PED_PHASE_EN
    logic unused_req;
    assign unused_req = bus.main_req;
`else
    logic unused_req;
    assign unused_req = bus.main_req ^ bus.walk_req;
`endif

    assign div_nxt      = (div_cnt == DIV_W'(DIV - 1)) ? '0 : div_cnt + 1'b1;
    assign enter_side_c = (state_nxt == SIDE_G) && (state != SIDE_G);

    // Next phase; transitions are only evaluated on tick cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            MAIN_G: begin
                if (tick_q && (phase_cnt >= CNT_W'(MIN_GREEN - 1)) && (side_pend || walk_pend))
                    state_nxt = MAIN_Y;
            end
            MAIN_Y: begin
                if (tick_q && (phase_cnt >= CNT_W'(YELLOW - 1)))
                    state_nxt = ALL_RED;
            end
            ALL_RED: begin
                if (tick_q) begin
                    if (!from_main)
                        state_nxt = MAIN_G;
                    else if (side_pend && (!ptr_walk || !walk_pend))
                        state_nxt = SIDE_G;
                    else if (walk_pend)
                        state_nxt = WALK;
                    else
                        state_nxt = MAIN_G;
                end
            end
            SIDE_G: begin
                if (tick_q && ((phase_cnt >= CNT_W'(MAX_GREEN - 1)) ||
                               ((phase_cnt >= CNT_W'(MIN_GREEN - 1)) && !bus.side_req)))
                    state_nxt = SIDE_Y;
            end
            SIDE_Y: begin
                if (tick_q && (phase_cnt >= CNT_W'(YELLOW - 1)))
                    state_nxt = ALL_RED;
            end
            WALK: begin
                if (tick_q && (phase_cnt >= CNT_W'(WALK_TIME - 1)))
                    state_nxt = ALL_RED;
            end
            default: state_nxt = MAIN_G;
        endcase
    end

    // Lamps follow the phase being entered so they line up with the state register.
    always_comb begin
        main_nxt = LAMP_R;
        side_nxt = LAMP_R;
        case (state_nxt)
            MAIN_G:  main_nxt = LAMP_G;
            MAIN_Y:  main_nxt = LAMP_Y;
            SIDE_G:  side_nxt = LAMP_G;
            SIDE_Y:  side_nxt = LAMP_Y;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MAIN_G;
            div_cnt   <= '0;
            tick_q    <= 1'b0;
            phase_cnt <= '0;
            side_pend <= 1'b0;
            from_main <= 1'b0;
            main_q    <= LAMP_G;
            side_q    <= LAMP_R;
            phase_q   <= 3'd0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            tick_q  <= (div_nxt == DIV_W'(DIV - 1));

            // Saturating tick count so an indefinitely held main green never wraps.
            if (state_nxt != state)
                phase_cnt <= '0;
            else if (tick_q && (phase_cnt != '1))
                phase_cnt <= phase_cnt + 1'b1;

            if (enter_side_c)
                side_pend <= 1'b0;
            else if (bus.side_req)
                side_pend <= 1'b1;

            if ((state_nxt == ALL_RED) && (state != ALL_RED))
                from_main <= (state == MAIN_Y);

            main_q  <= main_nxt;
            side_q  <= side_nxt;
            phase_q <= 3'(state_nxt);
        end
    end

`ifdef PED_PHASE_EN
    logic enter_walk_c;
    logic walk_q;

    assign enter_walk_c = (state_nxt == WALK) && (state != WALK);

    // Pedestrian demand latch and round-robin pointer (0 = side first, 1 = walk first).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            walk_pend <= 1'b0;
            ptr_walk  <= 1'b0;
            walk_q    <= 1'b0;
        end else begin
            if (enter_walk_c)
                walk_pend <= 1'b0;
            else if (bus.walk_req)
                walk_pend <= 1'b1;

            if (enter_side_c)
                ptr_walk <= 1'b1;
            else if (enter_walk_c)
                ptr_walk <= 1'b0;

            walk_q <= (state_nxt == WALK);
        end
    end

    assign bus.walk_light = walk_q;
`else
    assign walk_pend      = 1'b0;
    assign ptr_walk       = 1'b0;
    assign bus.walk_light = 1'b0;
`endif

    assign bus.main_light = main_q;
    assign bus.side_light = side_q;
    assign bus.tick       = tick_q;
    assign bus.phase      = phase_q;

endmodule

// File: tb/tb_intersection_arbiter.sv
// Randomised and directed bench for intersection_arbiter against a tick-level phase model.
// Honours PED_PHASE_EN the same way the design does.
module tb_intersection_arbiter;
    localparam int DIV       = 4;
    localparam int MIN_GREEN = 6;
    localparam int MAX_GREEN = 12;
    localparam int YELLOW    = 2;
    localparam int WALK_TIME = 5;
`ifdef PED_PHASE_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    localparam int P_MG = 0;
    localparam int P_MY = 1;
    localparam int P_AR = 2;
    localparam int P_SG = 3;
    localparam int P_SY = 4;
    localparam int P_WK = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    intersection_arbiter_if bus ();

    intersection_arbiter #(
        .DIV       (DIV),
        .MIN_GREEN (MIN_GREEN),
        .MAX_GREEN (MAX_GREEN),
        .YELLOW    (YELLOW),
        .WALK_TIME (WALK_TIME)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase id, ticks completed in phase, demand latches, round-robin.
    int m_div, m_ph, m_done, m_last_green;
    bit m_sp, m_wp, m_ptr_walk, m_tick;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] lamp_main(input int ph);
        return (ph == P_MG) ? 3'b001 : (ph == P_MY) ? 3'b010 : 3'b100;
    endfunction

    function automatic logic [2:0] lamp_side(input int ph);
        return (ph == P_SG) ? 3'b001 : (ph == P_SY) ? 3'b010 : 3'b100;
    endfunction

    task automatic model_reset();
        m_div = 0; m_ph = P_MG; m_done = 0; m_last_green = P_MG;
        m_sp = 0; m_wp = 0; m_ptr_walk = 0; m_tick = 0;
    endtask

    task automatic model_step(input bit s, input bit w);
        int  nph;
        int  done;
        bit  we;
        we  = PED && w;
        nph = m_ph;
        if (m_div == DIV - 1) begin
            done = m_done + 1;
            case (m_ph)
                P_MG: if (done >= MIN_GREEN && (m_sp || m_wp)) nph = P_MY;
                P_MY: if (done >= YELLOW) nph = P_AR;
                P_AR: begin
                    if (m_last_green != P_MG) nph = P_MG;
                    else if (m_sp && m_wp)    nph = m_ptr_walk ? P_WK : P_SG;
                    else if (m_sp)            nph = P_SG;
                    else if (m_wp)            nph = P_WK;
                    else                      nph = P_MG;
                end
                P_SG: if (done >= MAX_GREEN || (done >= MIN_GREEN && !s)) nph = P_SY;
                P_SY: if (done >= YELLOW) nph = P_AR;
                P_WK: if (done >= WALK_TIME) nph = P_AR;
                default: nph = P_MG;
            endcase
            m_done = (nph != m_ph) ? 0 : done;
        end
        m_sp = (nph == P_SG && m_ph != P_SG) ? 1'b0 : (m_sp | s);
        m_wp = (nph == P_WK && m_ph != P_WK) ? 1'b0 : (m_wp | we);
        if (nph != m_ph && (nph == P_MG || nph == P_SG || nph == P_WK)) m_last_green = nph;
        if (nph == P_SG && m_ph != P_SG) m_ptr_walk = 1'b1;
        if (nph == P_WK && m_ph != P_WK) m_ptr_walk = 1'b0;
        m_ph   = nph;
        m_div  = (m_div + 1) % DIV;
        m_tick = (m_div == DIV - 1);
    endtask

    task automatic compare_all();
        check("main_light", 32'(bus.main_light), 32'(lamp_main(m_ph)));
        check("side_light", 32'(bus.side_light), 32'(lamp_side(m_ph)));
        check("walk_light", 32'(bus.walk_light), 32'(m_ph == P_WK));
        check("tick", 32'(bus.tick), 32'(m_tick));
        check("phase", 32'(bus.phase), 32'(m_ph));
        check("main_onehot", 32'($countones(bus.main_light)), 32'd1);
        check("side_onehot", 32'($countones(bus.side_light)), 32'd1);
        check("road_conflict", 32'(bus.main_light != 3'b100 && bus.side_light != 3'b100), 32'd0);
    endtask

    // One clock: inputs applied at negedge, model stepped at posedge, outputs checked at next negedge.
    task automatic cycle(input bit s, input bit w);
        bus.side_req = s;
        bus.walk_req = w;
        bus.main_req = 1'($urandom_range(0, 1));
        @(posedge clk);
        model_step(s, w);
        @(negedge clk);
        compare_all();
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_main_light", 32'(bus.main_light), 32'h1);
        check("rst_side_light", 32'(bus.side_light), 32'h4);
        check("rst_walk_light", 32'(bus.walk_light), 32'h0);
        check("rst_phase", 32'(bus.phase), 32'h0);
        check("rst_tick", 32'(bus.tick), 32'h0);
        bus.side_req = 1'b0;
        bus.walk_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt_a, cnt_b, cnt_c, cnt_d, guard, side_hold;
        bit s, w, seen;

        bus.main_req = 1'b0;
        bus.side_req = 1'b0;
        bus.walk_req = 1'b0;
        model_reset();
        @(negedge clk);
        check("init_main_light", 32'(bus.main_light), 32'h1);
        check("init_side_light", 32'(bus.side_light), 32'h4);
        check("init_phase", 32'(bus.phase), 32'h0);
        check("init_tick", 32'(bus.tick), 32'h0);
        rst = 1'b0;

        // Idle: main green held, tick every DIV clocks.
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 1'b0);
            cnt_a += int'(bus.tick);
            cnt_b += int'(bus.phase != 3'd0);
        end
        check("idle_tick_count", 32'(cnt_a), 32'(200 / DIV));
        check("idle_not_main_g", 32'(cnt_b), 32'd0);

        // Single side pulse: one minimum side green, then back to main.
        async_reset();
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        cnt_a = 0;
        for (int i = 0; i < 150; i++) begin
            cycle(1'b0, 1'b0);
            cnt_a += int'(bus.side_light == 3'b001);
        end
        check("pulse_side_green_clks", 32'(cnt_a), 32'(MIN_GREEN * DIV));
        check("pulse_back_main", 32'(bus.phase), 32'(P_MG));

        // Side held: green capped at MAX_GREEN ticks.
        async_reset();
        cnt_a = 0; seen = 0; guard = 0;
        while (!(seen && bus.side_light == 3'b010) && guard < 400) begin
            cycle(1'b1, 1'b0);
            if (bus.side_light == 3'b001) begin
                seen = 1;
                cnt_a++;
            end
            guard++;
        end
        check("held_reached_side_y", 32'(bus.side_light), 32'h2);
        check("held_side_green_clks", 32'(cnt_a), 32'(MAX_GREEN * DIV));
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0);

`ifdef PED_PHASE_EN
        // Side and walk together: side first, main minimum green, then walk.
        async_reset();
        cycle(1'b1, 1'b1);
        cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
        for (int i = 0; i < 250; i++) begin
            cycle(1'b0, 1'b0);
            if (bus.side_light == 3'b001 && cnt_c == 0) cnt_a++;
            if (cnt_a > 0 && cnt_c == 0 && bus.main_light == 3'b001) cnt_b++;
            if (bus.phase == 3'(P_WK)) cnt_c++;
            cnt_d += int'(bus.walk_light);
        end
        check("both_side_first_clks", 32'(cnt_a), 32'(MIN_GREEN * DIV));
        check("both_main_between_clks", 32'(cnt_b), 32'(MIN_GREEN * DIV));
        check("both_walk_clks", 32'(cnt_c), 32'(WALK_TIME * DIV));
        check("both_walk_lamp_clks", 32'(cnt_d), 32'(WALK_TIME * DIV));
`else
        // Walk button ignored without the pedestrian phase.
        async_reset();
        cycle(1'b0, 1'b1);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 1'b0);
            cnt_a += int'(bus.phase != 3'd0);
            cnt_b += int'(bus.walk_light);
        end
        check("nowalk_not_main_g", 32'(cnt_a), 32'd0);
        check("nowalk_walk_lamp", 32'(cnt_b), 32'd0);
`endif

        // Reset in the middle of a side green, after its third tick.
        async_reset();
        cycle(1'b1, 1'b0);
        guard = 0;
        while (bus.phase != 3'(P_SG) && guard < 200) begin
            cycle(1'b1, 1'b0);
            guard++;
        end
        check("mid_reached_side_g", 32'(bus.phase), 32'(P_SG));
        cnt_a = 0; guard = 0;
        while (cnt_a < 3 && guard < 40) begin
            cycle(1'b1, 1'b0);
            cnt_a += int'(bus.tick);
            guard++;
        end
        cycle(1'b1, 1'b0);
        check("mid_still_side_g", 32'(bus.side_light), 32'h1);
        async_reset();
        cnt_a = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(1'b0, 1'b0);
            cnt_a += int'(bus.phase != 3'd0);
        end
        check("mid_pends_cleared", 32'(cnt_a), 32'd0);

        // Random demand with occasional held sensors and async resets.
        side_hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (side_hold == 0 && $urandom_range(0, 99) == 0) side_hold = int'($urandom_range(30, 80));
            s = (side_hold > 0) || ($urandom_range(0, 15) == 0);
            w = ($urandom_range(0, 29) == 0);
            if (side_hold > 0) side_hold--;
            if ($urandom_range(0, 499) == 0) async_reset();
            else cycle(s, w);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
